// File: rtl/counter_pkg.sv
// Shared helpers for the BCD up/down counter: width math, binary-to-BCD
// conversion for loads and constants, and direction encoding.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int BCD_MAX_DIGITS = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint pow10(input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p;
  endfunction

  // Double-dabble over a 32-bit value; digits at or above `digits` are forced to 0.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input logic [31:0] value,
                                                         input int digits);
    logic [4*BCD_MAX_DIGITS-1:0] b;
    b = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < BCD_MAX_DIGITS; d++)
        if (b[d*4 +: 4] >= 4'd5) b[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
      b = {b[4*BCD_MAX_DIGITS-2:0], value[i]};
    end
    for (int d = 0; d < BCD_MAX_DIGITS; d++)
      if (d >= digits) b[d*4 +: 4] = 4'h0;
    return b;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter chain: ripple carry on increment,
// ripple borrow on decrement, parallel load for clear/load/wrap.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       carry_out,
  output logic       borrow_out
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load)
      digit_d = load_digit;
    else if (inc && carry_in)
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    else if (dec && borrow_in)
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) digit_q <= 4'd0;
    else        digit_q <= digit_d;
  end

  assign digit      = digit_q;
  assign carry_out  = inc & carry_in  & (digit_q == 4'd9);
  assign borrow_out = dec & borrow_in & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Modulo 0..MAX_VALUE up/down counter with a binary register and a BCD digit
// chain kept in lock-step; wraps or saturates at the bounds.
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int  DIGITS    = 3,
  parameter int  MAX_VALUE = 999,
  parameter bit  SATURATE  = 1'b0,
  localparam int W         = clog2(MAX_VALUE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [W-1:0]          load_value,
  output logic [W-1:0]          count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  wrap
);

  if (MAX_VALUE < 1) begin : g_bad_max
    $error("bcd_updown_counter: MAX_VALUE must be >= 1");
  end
  if (pow10(DIGITS) <= longint'(MAX_VALUE)) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS too small to hold MAX_VALUE");
  end

  localparam logic [W-1:0] MAX_W = W'(MAX_VALUE);
  localparam logic [4*BCD_MAX_DIGITS-1:0] MAX_BCD64 = to_bcd(32'(MAX_VALUE), DIGITS);
  localparam logic [DIGITS-1:0][3:0] MAX_BCD = MAX_BCD64[4*DIGITS-1:0];

  logic [W-1:0]             count_q, count_d;
  logic                     wrap_q, wrap_d;
  logic [DIGITS-1:0][3:0]   bcd_q;

  logic                     bcd_load;
  logic [DIGITS-1:0][3:0]   bcd_load_val;
  logic                     inc, dec;

  logic [W-1:0]                 load_clamped;
  logic [4*BCD_MAX_DIGITS-1:0]  load_bcd64;

  assign at_max  = (count_q == MAX_W);
  assign at_zero = (count_q == '0);

  assign load_clamped = (load_value > MAX_W) ? MAX_W : load_value;
  assign load_bcd64   = to_bcd(32'(load_clamped), DIGITS);

  // Wraps, clears and loads all reach the digits through the parallel load;
  // only single steps ripple through the carry/borrow chain.
  always_comb begin
    count_d      = count_q;
    wrap_d       = 1'b0;
    bcd_load     = 1'b0;
    bcd_load_val = '0;
    inc          = 1'b0;
    dec          = 1'b0;
    if (clr) begin
      count_d  = '0;
      bcd_load = 1'b1;
    end else if (load) begin
      count_d      = load_clamped;
      bcd_load     = 1'b1;
      bcd_load_val = load_bcd64[4*DIGITS-1:0];
    end else if (en) begin
      if (up == DIR_UP) begin
        if (!at_max) begin
          count_d = count_q + 1'b1;
          inc     = 1'b1;
        end else if (!SATURATE) begin
          count_d  = '0;
          wrap_d   = 1'b1;
          bcd_load = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - 1'b1;
          dec     = 1'b1;
        end else if (!SATURATE) begin
          count_d      = MAX_W;
          wrap_d       = 1'b1;
          bcd_load     = 1'b1;
          bcd_load_val = MAX_BCD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  logic [DIGITS:0] carry, borrow;
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .inc        (inc),
      .dec        (dec),
      .carry_in   (carry[g]),
      .borrow_in  (borrow[g]),
      .load       (bcd_load),
      .load_digit (bcd_load_val[g]),
      .digit      (bcd_q[g]),
      .carry_out  (carry[g+1]),
      .borrow_out (borrow[g+1])
    );
  end

  assign count = count_q;
  assign bcd   = bcd_q;
  assign wrap  = wrap_q;

`ifndef SYNTHESIS
  logic [4*BCD_MAX_DIGITS-1:0] bcd_chk;
  assign bcd_chk = to_bcd(32'(count_q), DIGITS);

  // Steps never run off the top digit: increments stop below MAX, decrements above 0.
  always @(posedge clk) begin
    if (reset) begin
      assert (bcd_q == bcd_chk[4*DIGITS-1:0])
        else $error("bcd out of step with count");
      assert (!carry[DIGITS] && !borrow[DIGITS])
        else $error("carry/borrow out of top digit");
    end
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: three configurations checked every
// cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_bcd_updown_counter;

  localparam int NI = 3;
  localparam int MAXV [NI] = '{999, 59, 1};
  localparam bit SATV [NI] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bit c_en [NI];
  bit c_up [NI];
  bit c_clr [NI];
  bit c_load [NI];
  int c_lv [NI];

  logic [9:0]  cnt0; logic [11:0] bcd0; logic am0, az0, wr0;
  logic [5:0]  cnt1; logic [7:0]  bcd1; logic am1, az1, wr1;
  logic [0:0]  cnt2; logic [3:0]  bcd2; logic am2, az2, wr2;

  bcd_updown_counter u_def (
    .clk(clk), .reset(reset), .en(c_en[0]), .up(c_up[0]), .clr(c_clr[0]),
    .load(c_load[0]), .load_value(10'(c_lv[0])), .count(cnt0), .bcd(bcd0),
    .at_max(am0), .at_zero(az0), .wrap(wr0));

  bcd_updown_counter #(.DIGITS(2), .MAX_VALUE(59), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(c_en[1]), .up(c_up[1]), .clr(c_clr[1]),
    .load(c_load[1]), .load_value(6'(c_lv[1])), .count(cnt1), .bcd(bcd1),
    .at_max(am1), .at_zero(az1), .wrap(wr1));

  bcd_updown_counter #(.DIGITS(1), .MAX_VALUE(1), .SATURATE(1'b0)) u_one (
    .clk(clk), .reset(reset), .en(c_en[2]), .up(c_up[2]), .clr(c_clr[2]),
    .load(c_load[2]), .load_value(1'(c_lv[2])), .count(cnt2), .bcd(bcd2),
    .at_max(am2), .at_zero(az2), .wrap(wr2));

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  int m_cnt [NI] = '{0, 0, 0};
  bit m_wrap [NI] = '{1'b0, 1'b0, 1'b0};

  function automatic int ref_bcd(input int v);
    int r, x;
    r = 0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int next_cnt(input int i);
    if (c_clr[i])  return 0;
    if (c_load[i]) return (c_lv[i] > MAXV[i]) ? MAXV[i] : c_lv[i];
    if (!c_en[i])  return m_cnt[i];
    if (c_up[i])   return (m_cnt[i] == MAXV[i]) ? (SATV[i] ? MAXV[i] : 0) : m_cnt[i] + 1;
    return (m_cnt[i] == 0) ? (SATV[i] ? 0 : MAXV[i]) : m_cnt[i] - 1;
  endfunction

  function automatic bit next_wrap(input int i);
    if (c_clr[i] || c_load[i] || !c_en[i] || SATV[i]) return 1'b0;
    return c_up[i] ? (m_cnt[i] == MAXV[i]) : (m_cnt[i] == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i]  <= 0;
        m_wrap[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i]  <= next_cnt(i);
        m_wrap[i] <= next_wrap(i);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cmp(input int i, input int c, input int b, input bit am, input bit az,
                     input bit w);
    chk($sformatf("model%0d.count", i), c, m_cnt[i]);
    chk($sformatf("model%0d.bcd", i), b, ref_bcd(m_cnt[i]));
    chk($sformatf("model%0d.at_max", i), int'(am), int'(m_cnt[i] == MAXV[i]));
    chk($sformatf("model%0d.at_zero", i), int'(az), int'(m_cnt[i] == 0));
    chk($sformatf("model%0d.wrap", i), int'(w), int'(m_wrap[i]));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, int'(cnt0), int'(bcd0), am0, az0, wr0);
      cmp(1, int'(cnt1), int'(bcd1), am1, az1, wr1);
      cmp(2, int'(cnt2), int'(bcd2), am2, az2, wr2);
    end
  end

  task automatic drive(input int i, input bit e, input bit u, input bit c, input bit l,
                       input int lv);
    for (int k = 0; k < NI; k++) begin
      c_en[k] = 1'b0; c_up[k] = 1'b0; c_clr[k] = 1'b0; c_load[k] = 1'b0; c_lv[k] = 0;
    end
    c_en[i] = e; c_up[i] = u; c_clr[i] = c; c_load[i] = l; c_lv[i] = lv;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("reset.count", int'(cnt0), 0);
    chk("reset.bcd", int'(bcd0), 'h000);
    chk("reset.at_zero", int'(az0), 1);
    chk("reset.at_max", int'(am0), 0);
    chk("reset.wrap", int'(wr0), 0);
    reset = 1'b1;
    chk_on = 1'b1;

    // reset in the middle of a count, checked before any further edge
    drive(0, 0, 0, 0, 1, 57); tick();
    chk("load57.count", int'(cnt0), 57);
    chk("load57.bcd", int'(bcd0), 'h057);
    drive(0, 1, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("midreset.count", int'(cnt0), 0);
    chk("midreset.bcd", int'(bcd0), 'h000);
    chk("midreset.at_zero", int'(az0), 1);
    chk("midreset.wrap", int'(wr0), 0);
    tick();
    reset = 1'b1;

    // up-wrap
    drive(0, 0, 0, 0, 1, 998); tick();
    chk("upwrap.load", int'(cnt0), 998);
    drive(0, 1, 1, 0, 0, 0); tick();
    chk("upwrap.999", int'(cnt0), 999);
    chk("upwrap.at_max", int'(am0), 1);
    chk("upwrap.bcd999", int'(bcd0), 'h999);
    tick();
    chk("upwrap.zero", int'(cnt0), 0);
    chk("upwrap.wrap_hi", int'(wr0), 1);
    chk("upwrap.bcd0", int'(bcd0), 'h000);
    tick();
    chk("upwrap.one", int'(cnt0), 1);
    chk("upwrap.wrap_lo", int'(wr0), 0);

    // down-wrap
    drive(0, 0, 0, 1, 0, 0); tick();
    chk("downwrap.clr", int'(cnt0), 0);
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("downwrap.999", int'(cnt0), 999);
    chk("downwrap.bcd", int'(bcd0), 'h999);
    chk("downwrap.wrap_hi", int'(wr0), 1);
    tick();
    chk("downwrap.998", int'(cnt0), 998);
    chk("downwrap.wrap_lo", int'(wr0), 0);

    // priority and clamp
    drive(0, 0, 0, 0, 1, 500); tick();
    drive(0, 1, 1, 1, 1, 7); tick();
    chk("prio.clr_wins", int'(cnt0), 0);
    drive(0, 1, 1, 0, 1, 1023); tick();
    chk("clamp.count", int'(cnt0), 999);
    chk("clamp.bcd", int'(bcd0), 'h999);

    // hold with up toggling
    drive(0, 0, 0, 0, 1, 123); tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, k[0], 0, 0, 0); tick();
      chk("hold.count", int'(cnt0), 123);
      chk("hold.bcd", int'(bcd0), 'h123);
      chk("hold.wrap", int'(wr0), 0);
    end

    // saturating 0..59, two digits
    drive(1, 0, 0, 0, 1, 9); tick();
    chk("sat.bcd09", int'(bcd1), 'h09);
    drive(1, 1, 1, 0, 0, 0); tick();
    chk("sat.bcd10", int'(bcd1), 'h10);
    drive(1, 0, 0, 0, 1, 58); tick();
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat.top", int'(cnt1), 59);
      chk("sat.top_wrap", int'(wr1), 0);
    end
    drive(1, 0, 0, 0, 1, 63); tick();
    chk("sat.clamp", int'(cnt1), 59);
    drive(1, 0, 0, 1, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sat.bottom", int'(cnt1), 0);
      chk("sat.bottom_wrap", int'(wr1), 0);
    end

    // MAX_VALUE=1: alternating direction gives back-to-back wraps
    drive(2, 0, 0, 0, 1, 1); tick();
    drive(2, 1, 1, 0, 0, 0); tick();
    chk("one.up_wrap", int'(cnt2), 0);
    chk("one.wrap1", int'(wr2), 1);
    drive(2, 1, 0, 0, 0, 0); tick();
    chk("one.down_wrap", int'(cnt2), 1);
    chk("one.wrap2", int'(wr2), 1);
    drive(2, 1, 1, 0, 0, 0); tick();
    chk("one.wrap3", int'(wr2), 1);

    // long walk on all three, crossing digit carries and borrows
    for (int i = 0; i < NI; i++) begin
      c_en[i] = 1'b0; c_up[i] = 1'b0; c_clr[i] = 1'b0; c_load[i] = 1'b1;
      c_lv[i] = (i == 0) ? 95 : 0;
    end
    tick();
    for (int k = 0; k < 1200; k++) begin
      for (int i = 0; i < NI; i++) begin
        c_load[i] = 1'b0;
        c_en[i]   = (k % 9) != 4;
        c_up[i]   = k < 700;
      end
      tick();
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised up/down modulo counter that replaces the fixed 0-to-999 counter in the lab datapath. It counts from 0 to a configurable maximum, either wrapping or saturating at the bounds. It adds enable, direction, synchronous clear and load, and a packed-BCD output that feeds the seven-segment display driver directly. Binary and BCD values are kept in lock-step in registers, so no downstream conversion is needed.

## Interface
- DIGITS, 3, number of BCD digits on `bcd`; must satisfy 10^DIGITS > MAX_VALUE (elaboration error otherwise)
- MAX_VALUE, 999, largest count value, ≥ 1
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds
- Derived W = clog2(MAX_VALUE+1), width of `count` and `load_value`
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset)
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous load of `load_value`
- load_value  input  W  value to load (binary)
- count  output  W  current value, binary
- bcd  output  4*DIGITS  current value, packed BCD, digit 0 in [3:0]
- at_max  output  1  count == MAX_VALUE
- at_zero  output  1  count == 0
- wrap  output  1  one-cycle pulse, high in the cycle after a wrap edge

## Operation
- **Reset:**
  - Asserted: count=0, bcd=0, wrap=0, hence at_zero=1 and at_max=0, immediately and with no clock.
  - Deassertion takes effect at the next rising edge.
- **Per-edge priority:** clr > load > en; `up` is ignored when en=0.
- **clr:** count=0, bcd=0, wrap=0.
- **load:**
  - count = min(load_value, MAX_VALUE); bcd = BCD of that value; wrap=0.
  - Loads above MAX_VALUE clamp to MAX_VALUE.
- **en, up=1:**
  - Below MAX: count+1.
  - At MAX with SATURATE=0: count=0, wrap=1.
  - At MAX with SATURATE=1: hold, wrap=0.
- **en, up=0:**
  - Above 0: count-1.
  - At 0 with SATURATE=0: count=MAX_VALUE, wrap=1.
  - At 0 with SATURATE=1: hold, wrap=0.
- **en=0, no clr/load:** hold; wrap=0.
- **BCD stepping:**
  - Increment: a digit at 9 rolls to 0 and carries into the next digit.
  - Decrement: a digit at 0 rolls to 9 and borrows from the next digit.
  - Wrap-to-zero and wrap-to-MAX write bcd directly from constants; the digit chain is not used for wraps.
- **BCD width:** digits above the significant range always read 0.
- **Invariant:** bcd always equals the decimal of count, checked every cycle in simulation.

## Timing
- All state is registered on the rising edge of clk; latency is 1 cycle from an input to count/bcd.
- `wrap` is registered in the same edge as the wrapping count update. It is high for exactly one cycle and low on the following edge unless another wrap occurs.
- `at_max` and `at_zero` are combinational from the count register, with no added latency.
- Back-to-back wraps with MAX_VALUE=1: wrap stays high on consecutive cycles.
- Reset asserted mid-count aborts at once; no partial BCD state survives.

## Structure
- **Package `counter_pkg`:**
  - function clog2
  - function to_bcd(value, digits), combinational double-dabble, used for load and constants
  - constants DIR_UP=1, DIR_DOWN=0
- **Sub-module `bcd_digit`:**
  - One 4-bit decimal digit with inc, dec, carry_in/borrow_in and carry_out/borrow_out.
  - Supports a parallel load and an asynchronous active-low reset.
  - `bcd_updown_counter` instantiates DIGITS of these in a generate chain.
- **Top level:** the binary register, bound detection, priority logic and the wrap register.

## Test plan
- Reset mid-count: count=57, pull reset low between edges -> count=0, bcd=12'h000, at_zero=1, wrap=0 before the next edge.
- Up-wrap (defaults): load 998, en=1, up=1 -> edges give 999 (at_max=1, bcd=12'h999), then 0 with wrap=1 for exactly one cycle, then 1 with wrap=0.
- Down-wrap (defaults): clr, then en=1, up=0 -> count=999, bcd=12'h999, wrap=1 for one cycle; next edge count=998.
- Saturate (MAX_VALUE=59, DIGITS=2, SATURATE=1):
  - At 59 with up -> holds 59, wrap never asserts.
  - At 0 with down -> holds 0.
  - Carry check: 09 -> 10 gives bcd=8'h10.
- Priority and clamp (defaults):
  - At 500, clr=load=en=1 -> count=0.
  - Next edge load=1, load_value=1023, en=1 -> count=999, bcd=12'h999.
- Hold: en=0 for 10 cycles at 123 -> count=123, bcd=12'h123, wrap=0 throughout; `up` toggling has no effect.
